a2wb_cmd_arb: RTL and testbench

//  Arbitrates single-outstanding data-side commands from up to NREQ cores onto one shared

---
 rtl/a2wb_cmd_arb.sv | 132 +++++++++++++
 tb/tb_a2wb_cmd_arb.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2wb_cmd_arb.sv
// Round-robin arbiter: NREQ single-outstanding commands onto one classic Wishbone bus with timeout.
// Latency: grant->wb_cyc 1 cycle, wb_ack->req_ack 1 cycle; requesters hold req_valid until req_ack.
module a2wb_cmd_arb #(
    parameter int NREQ    = 4,
    parameter int TMO_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_we,
    input  logic [4*NREQ-1:0]    req_sel,
    input  logic [32*NREQ-1:0]   req_adr,
    input  logic [32*NREQ-1:0]   req_datw,
    input  logic [8*NREQ-1:0]    req_ext,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_err,
    output logic [31:0]          rsp_datr,
    output logic                 wb_cyc,
    output logic                 wb_stb,
    output logic                 wb_we,
    output logic [3:0]           wb_sel,
    output logic [31:0]          wb_adr,
    output logic [31:0]          wb_datw,
    output logic [7:0]           wb_ext,
    input  logic                 wb_ack,
    input  logic                 wb_err,
    input  logic [31:0]          wb_datr,
    output logic [1:0]           gnt_id
);

    typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

    state_t      state;
    logic [1:0]  rr_ptr;
    logic [7:0]  tmo_cnt;

    logic        found;
    logic [1:0]  winner;
    logic [1:0]  rr_next;

    logic        bus_done;
    logic        bus_fail;
    logic [31:0] bus_dat;
    logic [NREQ-1:0] gnt_vec;

    // Search starts at rr_ptr so the least-recently-granted requester wins.
    always_comb begin
        found  = 1'b0;
        winner = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[(int'(rr_ptr) + i) % NREQ]) begin
                found  = 1'b1;
                winner = 2'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end

    assign rr_next = (winner == 2'(NREQ - 1)) ? 2'd0 : winner + 2'd1;
    assign gnt_vec = NREQ'(1) << gnt_id;
    assign wb_stb  = wb_cyc;

    // Termination priority: ack, then slave error, then timeout.
    always_comb begin
        bus_done = 1'b0;
        bus_fail = 1'b0;
        bus_dat  = 32'h0;
        if (wb_ack) begin
            bus_done = 1'b1;
            bus_dat  = wb_datr;
        end else if (wb_err) begin
            bus_done = 1'b1;
            bus_fail = 1'b1;
        end else if (tmo_cnt == 8'(TMO_CYC - 1)) begin
            bus_done = 1'b1;
            bus_fail = 1'b1;
            bus_dat  = 32'hFFFF_FFFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= 2'd0;
            tmo_cnt  <= 8'd0;
            gnt_id   <= 2'd0;
            wb_cyc   <= 1'b0;
            wb_we    <= 1'b0;
            wb_sel   <= 4'h0;
            wb_adr   <= 32'h0;
            wb_datw  <= 32'h0;
            wb_ext   <= 8'h0;
            req_ack  <= '0;
            req_err  <= '0;
            rsp_datr <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        wb_we   <= req_we[winner];
                        wb_sel  <= req_sel[int'(winner)*4 +: 4];
                        wb_adr  <= req_adr[int'(winner)*32 +: 32];
                        wb_datw <= req_datw[int'(winner)*32 +: 32];
                        wb_ext  <= req_ext[int'(winner)*8 +: 8];
                        gnt_id  <= winner;
                        rr_ptr  <= rr_next;
                        wb_cyc  <= 1'b1;
                        state   <= BUS;
                    end
                end
                BUS: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (bus_done) begin
                        wb_cyc   <= 1'b0;
                        req_ack  <= gnt_vec;
                        req_err  <= bus_fail ? gnt_vec : '0;
                        rsp_datr <= bus_dat;
                        state    <= RSP;
                    end
                end
                RSP: begin
                    req_ack  <= '0;
                    req_err  <= '0;
                    rsp_datr <= 32'h0;
                    tmo_cnt  <= 8'd0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2wb_cmd_arb.sv
// Scoreboard bench for a2wb_cmd_arb: directed commands, scripted Wishbone slave, decoupled monitor.
module tb_a2wb_cmd_arb;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_we;
    logic [4*NREQ-1:0]   req_sel;
    logic [32*NREQ-1:0]  req_adr;
    logic [32*NREQ-1:0]  req_datw;
    logic [8*NREQ-1:0]   req_ext;
    logic [NREQ-1:0]     req_ack;
    logic [NREQ-1:0]     req_err;
    logic [31:0]         rsp_datr;
    logic                wb_cyc;
    logic                wb_stb;
    logic                wb_we;
    logic [3:0]          wb_sel;
    logic [31:0]         wb_adr;
    logic [31:0]         wb_datw;
    logic [7:0]          wb_ext;
    logic                wb_ack;
    logic                wb_err;
    logic [31:0]         wb_datr;
    logic [1:0]          gnt_id;

    a2wb_cmd_arb #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_sel(req_sel),
        .req_adr(req_adr), .req_datw(req_datw), .req_ext(req_ext),
        .req_ack(req_ack), .req_err(req_err), .rsp_datr(rsp_datr),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
        .wb_adr(wb_adr), .wb_datw(wb_datw), .wb_ext(wb_ext),
        .wb_ack(wb_ack), .wb_err(wb_err), .wb_datr(wb_datr),
        .gnt_id(gnt_id)
    );

    // Slave response kinds: 0 ack, 1 err, 2 silent (timeout), 3 ack+err together.
    typedef struct {
        int          kind;
        int          dly;
        logic [31:0] dat;
    } plan_t;

    typedef struct {
        logic [1:0]  gnt;
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] datw;
        logic [7:0]  ext;
        int          len;
    } bus_exp_t;

    typedef struct {
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [31:0] dat;
    } rsp_exp_t;

    plan_t    plan_q[$];
    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Scripted Wishbone slave: responds on the dly-th cycle of each bus cycle.
    initial begin : slave
        int    bus_n;
        plan_t cur;
        bus_n   = 0;
        cur     = '{kind: 2, dly: 0, dat: 32'h0};
        wb_ack  = 1'b0;
        wb_err  = 1'b0;
        wb_datr = 32'h0;
        forever begin
            @(negedge clk);
            wb_ack  = 1'b0;
            wb_err  = 1'b0;
            wb_datr = 32'h0;
            if (wb_cyc) begin
                if (bus_n == 0) begin
                    if (plan_q.size() > 0) cur = plan_q.pop_front();
                    else cur = '{kind: 2, dly: 0, dat: 32'h0};
                end
                if (bus_n == cur.dly) begin
                    wb_datr = cur.dat;
                    case (cur.kind)
                        0: wb_ack = 1'b1;
                        1: wb_err = 1'b1;
                        3: begin wb_ack = 1'b1; wb_err = 1'b1; end
                        default: ;
                    endcase
                end
                bus_n++;
            end else begin
                bus_n = 0;
            end
        end
    end

    initial begin : monitor
        bit       prev;
        int       len;
        bus_exp_t be;
        rsp_exp_t re;
        prev = 1'b0;
        len  = 0;
        be   = '{gnt: 2'd0, adr: 32'h0, we: 1'b0, sel: 4'h0, datw: 32'h0, ext: 8'h0, len: 0};
        forever begin
            @(negedge clk);
            if (wb_cyc) begin
                chk("wb_stb", 32'(wb_stb), 32'd1);
                if (!prev) begin
                    len = 0;
                    if (bus_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL bus_start: unexpected bus cycle gnt_id=%0d adr=%h", gnt_id, wb_adr);
                        be.len = 0;
                    end else begin
                        be = bus_q.pop_front();
                        chk("gnt_id", 32'(gnt_id), 32'(be.gnt));
                        chk("wb_adr", wb_adr, be.adr);
                        chk("wb_we", 32'(wb_we), 32'(be.we));
                        chk("wb_sel", 32'(wb_sel), 32'(be.sel));
                        chk("wb_datw", wb_datw, be.datw);
                        chk("wb_ext", 32'(wb_ext), 32'(be.ext));
                    end
                end
                len++;
            end else if (prev && be.len != 0) begin
                chk("wb_cyc_len", 32'(len), 32'(be.len));
            end
            prev = wb_cyc;
            if (req_ack != '0) begin
                if (rsp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL req_ack: unexpected ack %b", req_ack);
                end else begin
                    re = rsp_q.pop_front();
                    chk("req_ack", 32'(req_ack), 32'(re.ack));
                    chk("req_err", 32'(req_err), 32'(re.err));
                    chk("rsp_datr", rsp_datr, re.dat);
                end
            end else begin
                chk("idle_rsp_datr", rsp_datr, 32'h0);
                chk("idle_req_err", 32'(req_err), 32'h0);
            end
        end
    end

    task automatic set_req(input int r, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] datw, input logic [7:0] ext);
        req_we[r]             = we;
        req_sel[r*4 +: 4]     = sel;
        req_adr[r*32 +: 32]   = adr;
        req_datw[r*32 +: 32]  = datw;
        req_ext[r*8 +: 8]     = ext;
    endtask

    task automatic expect_txn(input int r, input int kind, input int dly, input logic [31:0] sdat,
                              input int len, input logic err, input logic [31:0] edat);
        logic [3:0] onehot;
        onehot = 4'(1 << r);
        plan_q.push_back('{kind: kind, dly: dly, dat: sdat});
        bus_q.push_back('{gnt: 2'(r), adr: req_adr[r*32 +: 32], we: req_we[r], sel: req_sel[r*4 +: 4],
                          datw: req_datw[r*32 +: 32], ext: req_ext[r*8 +: 8], len: len});
        rsp_q.push_back('{ack: onehot, err: err ? onehot : 4'h0, dat: edat});
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_ack == '0 && n < 200);
        if (req_ack == '0) begin
            total++; bad++;
            $display("FAIL %s: no req_ack within 200 cycles", tag);
        end
    endtask

    task automatic txn(input int r, input int kind, input int dly, input logic [31:0] sdat,
                       input int len, input logic err, input logic [31:0] edat, input string tag);
        expect_txn(r, kind, dly, sdat, len, err, edat);
        req_valid[r] = 1'b1;
        wait_ack(tag);
        req_valid[r] = 1'b0;
    endtask

    initial begin : stim
        int seq[11] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 3};
        int n;
        rst       = 1'b1;
        req_valid = '0;
        req_we    = '0;
        req_sel   = '0;
        req_adr   = '0;
        req_datw  = '0;
        req_ext   = '0;
        repeat (3) @(negedge clk);
        chk("rst_wb_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_req_ack", 32'(req_ack), 32'd0);
        chk("rst_gnt_id", 32'(gnt_id), 32'd0);
        chk("rst_wb_adr", wb_adr, 32'h0);
        chk("rst_rsp_datr", rsp_datr, 32'h0);
        rst = 1'b0;

        // Round-robin with all requesters held; requester 2 drops after its second grant.
        for (int r = 0; r < NREQ; r++)
            set_req(r, 1'b0, 4'hF, 32'h4000 + 32'(r * 16), 32'(r), 8'(r));
        for (int k = 0; k < 11; k++)
            expect_txn(seq[k], 0, 1, 32'hA000_0000 + 32'(k), 2, 1'b0, 32'hA000_0000 + 32'(k));
        req_valid = 4'hF;
        for (int k = 0; k < 11; k++) begin
            wait_ack("t2_rr");
            if (k == 6) req_valid[2] = 1'b0;
        end
        req_valid = '0;

        set_req(0, 1'b0, 4'hF, 32'h0000_1000, 32'h0, 8'h00);
        txn(0, 0, 2, 32'hDEAD_BEEF, 3, 1'b0, 32'hDEAD_BEEF, "t1_load");

        set_req(1, 1'b1, 4'h3, 32'h0000_2000, 32'h1234_5678, 8'h5A);
        txn(1, 0, 0, 32'h0, 1, 1'b0, 32'h0, "t3_store");

        txn(0, 2, 0, 32'h0, TMO, 1'b1, 32'hFFFF_FFFF, "t4_timeout");
        txn(0, 1, 2, 32'h55AA_55AA, 3, 1'b1, 32'h0, "t5_err");
        txn(0, 0, TMO - 1, 32'h0BAD_F00D, TMO, 1'b0, 32'h0BAD_F00D, "t5_ack_tmo");
        txn(0, 3, 1, 32'hCAFE_F00D, 2, 1'b0, 32'hCAFE_F00D, "t5_ack_err");

        // Reset between edges while requester 2 owns the bus.
        set_req(2, 1'b0, 4'hF, 32'h0000_3000, 32'h0, 8'h00);
        plan_q.push_back('{kind: 2, dly: 0, dat: 32'h0});
        bus_q.push_back('{gnt: 2'd2, adr: 32'h0000_3000, we: 1'b0, sel: 4'hF,
                          datw: 32'h0, ext: 8'h00, len: 0});
        req_valid[2] = 1'b1;
        n = 0;
        while (!wb_cyc && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_bus_started", 32'(wb_cyc), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_async_wb_cyc", 32'(wb_cyc), 32'd0);
        chk("t6_async_req_ack", 32'(req_ack), 32'd0);
        req_valid = 4'hF;
        set_req(0, 1'b0, 4'hF, 32'h0000_5000, 32'h0, 8'h11);
        expect_txn(0, 0, 0, 32'h600D_CAFE, 1, 1'b0, 32'h600D_CAFE);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ack("t6_after_reset");
        req_valid = '0;

        repeat (5) @(negedge clk);
        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        chk("plan_q_empty", 32'(plan_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
